// File: rtl/arbitro_memoria_if.sv
`default_nettype none
// ==========================================================================
// arbitro_memoria_if : requester handshakes and memory bus of the arbiter
// Rev 1.0
// ==========================================================================
interface arbitro_memoria_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] dir0;
  logic [DW-1:0] din0;
  logic          ack0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] dir1;
  logic [DW-1:0] din1;
  logic          ack1;

  logic          err;
  logic [DW-1:0] dato_rd;
  logic          busy;

  logic [AW-1:0] mem_dir;
  logic [DW-1:0] mem_din;
  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_dato;

  // Arbiter side
  modport slave (
    input  req0, we0, dir0, din0,
    input  req1, we1, dir1, din1,
    input  mem_dato,
    output ack0, ack1, err, dato_rd, busy,
    output mem_dir, mem_din, mem_en, mem_we
  );

  // Requesters plus memory side
  modport master (
    output req0, we0, dir0, din0,
    output req1, we1, dir1, din1,
    output mem_dato,
    input  ack0, ack1, err, dato_rd, busy,
    input  mem_dir, mem_din, mem_en, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_memoria.sv
`default_nettype none
// ==========================================================================
// arbitro_memoria : round-robin sequencer sharing one single-port memory
// between two requesters.  Rev 1.0
// ==========================================================================
module arbitro_memoria #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  arbitro_memoria_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One extra bit so a DEPTH equal to 2**AW still compares correctly
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  state_t        state, state_nx;
  logic          prio, prio_nx;
  logic          owner, owner_nx;
  logic          cmd_we, we_nx;
  logic          cmd_oor, oor_nx;
  logic          ack0_q, ack0_nx;
  logic          ack1_q, ack1_nx;
  logic          err_q, err_nx;
  logic [DW-1:0] dato_q, dato_nx;
  logic          busy_q, busy_nx;
  logic [AW-1:0] mdir_q, mdir_nx;
  logic [DW-1:0] mdin_q, mdin_nx;
  logic          men_q, men_nx;
  logic          mwe_q, mwe_nx;

  logic          any_req;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_dir;
  logic [DW-1:0] sel_din;
  logic          sel_oor;

  assign any_req  = bus.req0 | bus.req1;
  assign grant_id = (bus.req0 & bus.req1) ? prio : bus.req1;
  assign sel_we   = grant_id ? bus.we1  : bus.we0;
  assign sel_dir  = grant_id ? bus.dir1 : bus.dir0;
  assign sel_din  = grant_id ? bus.din1 : bus.din0;
  assign sel_oor  = ({1'b0, sel_dir} >= DEPTH_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= 1'b0;
      owner   <= 1'b0;
      cmd_we  <= 1'b0;
      cmd_oor <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      dato_q  <= '0;
      busy_q  <= 1'b0;
      mdir_q  <= '0;
      mdin_q  <= '0;
      men_q   <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      prio    <= prio_nx;
      owner   <= owner_nx;
      cmd_we  <= we_nx;
      cmd_oor <= oor_nx;
      ack0_q  <= ack0_nx;
      ack1_q  <= ack1_nx;
      err_q   <= err_nx;
      dato_q  <= dato_nx;
      busy_q  <= busy_nx;
      mdir_q  <= mdir_nx;
      mdin_q  <= mdin_nx;
      men_q   <= men_nx;
      mwe_q   <= mwe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    owner_nx = owner;
    we_nx    = cmd_we;
    oor_nx   = cmd_oor;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    err_nx   = 1'b0;
    dato_nx  = dato_q;
    busy_nx  = busy_q;
    mdir_nx  = mdir_q;
    mdin_nx  = mdin_q;
    men_nx   = 1'b0;
    mwe_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nx = grant_id;
          prio_nx  = ~grant_id;
          we_nx    = sel_we;
          oor_nx   = sel_oor;
          busy_nx  = 1'b1;
          state_nx = ACCESS;
          // Out-of-range commands never touch the memory bus
          if (!sel_oor) begin
            men_nx  = 1'b1;
            mwe_nx  = sel_we;
            mdir_nx = sel_dir;
            mdin_nx = sel_din;
          end
        end
      end
      ACCESS: state_nx = CAPTURE;
      CAPTURE: begin
        if (!cmd_we && !cmd_oor) begin
          dato_nx = bus.mem_dato;
        end
        ack0_nx  = ~owner;
        ack1_nx  = owner;
        err_nx   = cmd_oor;
        state_nx = DONE;
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.err     = err_q;
  assign bus.dato_rd = dato_q;
  assign bus.busy    = busy_q;
  assign bus.mem_dir = mdir_q;
  assign bus.mem_din = mdin_q;
  assign bus.mem_en  = men_q;
  assign bus.mem_we  = mwe_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria.sv
`default_nettype none
// ==========================================================================
// tb_arbitro_memoria : scoreboard bench with two requester drivers, a memory
// model and a transaction-level reference.  Rev 1.0
// ==========================================================================
module tb_arbitro_memoria;

  localparam int DEPTH = 11;

  typedef struct {
    bit         we;
    logic [7:0] dir;
    logic [7:0] din;
    int         gap;
    bit         early;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_memoria_if #(.DW(8), .AW(8)) bus ();

  arbitro_memoria #(.DW(8), .AW(8), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester-side state
  logic       req_v [2] = '{1'b0, 1'b0};
  logic       we_v  [2] = '{1'b0, 1'b0};
  logic [7:0] dir_v [2] = '{8'd0, 8'd0};
  logic [7:0] din_v [2] = '{8'd0, 8'd0};
  bit         outs  [2] = '{1'b0, 1'b0};
  bit         early_c [2] = '{1'b0, 1'b0};
  int         gap_c [2] = '{0, 0};
  int         raise_cyc [2] = '{0, 0};
  cmd_t       cmdq [2][$];
  cmd_t       expq [2][$];

  assign bus.req0 = req_v[0];
  assign bus.we0  = we_v[0];
  assign bus.dir0 = dir_v[0];
  assign bus.din0 = din_v[0];
  assign bus.req1 = req_v[1];
  assign bus.we1  = we_v[1];
  assign bus.dir1 = dir_v[1];
  assign bus.din1 = din_v[1];

  function automatic logic [7:0] init_val(input int a);
    if (a == 9)  return 8'd1;
    if (a == 10) return 8'd100;
    return 8'(90 - 10 * a);
  endfunction

  // Memory device: synchronous, one-cycle read latency
  logic [7:0] mem [DEPTH];
  initial for (int a = 0; a < DEPTH; a++) mem[a] = init_val(a);

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_dir < DEPTH) begin
      if (bus.mem_we) mem[bus.mem_dir] <= bus.mem_din;
      else            bus.mem_dato <= mem[bus.mem_dir];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input bit we, input int dir, input int din,
                              input int gap, input bit early);
    cmd_t c;
    c.we    = we;
    c.dir   = dir[7:0];
    c.din   = din[7:0];
    c.gap   = gap;
    c.early = early;
    return c;
  endfunction

  // Drivers: hold req until ack, then issue the next queued command
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        req_v[i] = 1'b0;
        outs[i]  = 1'b0;
        gap_c[i] = 0;
        expq[i].delete();
      end else begin
        if (outs[i] && ((i == 0) ? bus.ack0 : bus.ack1)) begin
          outs[i]  = 1'b0;
          req_v[i] = 1'b0;
        end else if (outs[i] && early_c[i] && req_v[i] && cyc == raise_cyc[i] + 2) begin
          req_v[i] = 1'b0;
        end
        if (!outs[i]) begin
          if (gap_c[i] > 0) begin
            gap_c[i]--;
          end else if (cmdq[i].size() > 0) begin
            cmd_t c;
            c = cmdq[i].pop_front();
            req_v[i]     = 1'b1;
            we_v[i]      = c.we;
            dir_v[i]     = c.dir;
            din_v[i]     = c.din;
            gap_c[i]     = c.gap;
            early_c[i]   = c.early;
            raise_cyc[i] = cyc;
            outs[i]      = 1'b1;
            expq[i].push_back(c);
          end
        end
      end
    end
  end

  // Reference model state
  logic [7:0] ref_mem [DEPTH];
  initial for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_val(a);
  bit         model_prio = 1'b0;
  logic [7:0] last_dato  = 8'd0;
  bit         prev_ack   = 1'b0;
  bit         prev_en    = 1'b0;
  int         en_cyc     = 0;
  int         en_pulses  = 0;
  int         inrange_cmds = 0;
  int         ack_count  = 0;
  int         ack_cyc_q [$];
  bit         ack_own_q [$];

  // Monitor: per-cycle protocol checks and scoreboard pops on each ack
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {bus.ack0, bus.ack1, bus.err, bus.dato_rd, bus.busy,
                            bus.mem_dir, bus.mem_din, bus.mem_en, bus.mem_we}, 0);
      model_prio   = 1'b0;
      last_dato    = 8'd0;
      prev_ack     = 1'b0;
      prev_en      = 1'b0;
      en_pulses    = 0;
      inrange_cmds = 0;
    end else begin
      chk("ack_exclusive", bus.ack0 & bus.ack1, 0);
      chk("ack_one_cycle", (bus.ack0 | bus.ack1) & prev_ack, 0);
      chk("mem_we_without_en", bus.mem_we & ~bus.mem_en, 0);
      chk("mem_en_one_cycle", bus.mem_en & prev_en, 0);
      if (bus.mem_en) begin
        en_pulses++;
        en_cyc = cyc;
        chk("mem_dir_in_range", bus.mem_dir < DEPTH, 1);
        chk("busy_with_en", bus.busy, 1);
      end
      if (bus.ack0 | bus.ack1) begin
        int   x;
        int   y;
        bit   oor;
        cmd_t c;
        x = bus.ack1 ? 1 : 0;
        y = 1 - x;
        ack_count++;
        ack_cyc_q.push_back(cyc);
        ack_own_q.push_back(x[0]);
        chk("busy_with_ack", bus.busy, 1);
        if (expq[x].size() == 0) begin
          chk("ack_expected", 0, 1);
        end else begin
          c   = expq[x].pop_front();
          oor = (c.dir >= DEPTH);
          // Grant happened two edges before the ack; was the other side waiting then?
          if (outs[y] && raise_cyc[y] + 1 <= cyc - 2)
            chk("rr_grant_owner", x, model_prio);
          model_prio = (x == 0);
          if (!oor) begin
            inrange_cmds++;
            chk("ack_latency", cyc - en_cyc, 2);
          end
          if (!c.we && !oor) last_dato = ref_mem[c.dir];
          if (c.we && !oor)  ref_mem[c.dir] = c.din;
          chk("err", bus.err, oor);
          chk("dato_rd", bus.dato_rd, last_dato);
        end
      end
      prev_ack = bus.ack0 | bus.ack1;
      prev_en  = bus.mem_en;
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (cmdq[0].size() + cmdq[1].size() + expq[0].size() + expq[1].size() != 0
           || outs[0] || outs[1]) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("wait_done_timeout", n, budget);
        cmdq[0].delete();
        cmdq[1].delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input int start, input int count, input bit alternate,
                           input bit first);
    chk("ack_log_count", ack_cyc_q.size() - start, count);
    for (int k = start; k < ack_cyc_q.size(); k++) begin
      chk("ack_owner_order", ack_own_q[k], alternate ? (first ^ ((k - start) % 2)) : first);
      if (k > start) chk("ack_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 4);
    end
  endtask

  initial begin
    int start;
    int acks_before;
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back
    cmdq[0].push_back(mk(1, 5, 99, 0, 0));
    cmdq[0].push_back(mk(0, 5, 0, 0, 0));
    wait_done(100);
    chk("readback_99", bus.dato_rd, 99);

    // Asynchronous reset while the memory access is in flight
    cmdq[0].push_back(mk(0, 2, 0, 0, 0));
    n = 0;
    while (!bus.mem_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("saw_mem_en_before_reset", bus.mem_en, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {bus.ack0, bus.ack1, bus.err, bus.dato_rd, bus.busy,
                                   bus.mem_dir, bus.mem_din, bus.mem_en, bus.mem_we}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    acks_before = ack_count;
    repeat (8) @(negedge clk);
    chk("no_ack_after_reset", ack_count, acks_before);

    // Contention from reset: both requesters waiting, owners must alternate from 0
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmdq[0].push_back(mk(0, 3, 0, 0, 0));
      cmdq[1].push_back(mk(0, 4, 0, 0, 0));
    end
    repeat (2) @(negedge clk);
    start = ack_cyc_q.size();
    rst_n = 1'b1;
    wait_done(200);
    check_log(start, 6, 1'b1, 1'b0);

    // Out-of-range read leaves dato_rd alone; next in-range command clears err
    cmdq[1].push_back(mk(0, 11, 0, 0, 0));
    cmdq[1].push_back(mk(0, 2, 0, 0, 0));
    cmdq[0].push_back(mk(1, 200, 7, 0, 0));
    wait_done(200);

    // Single requester streaming the whole memory
    start = ack_cyc_q.size();
    for (int a = 0; a < DEPTH; a++) cmdq[1].push_back(mk(0, a, 0, 0, 0));
    wait_done(300);
    check_log(start, DEPTH, 1'b0, 1'b1);

    // Requester drops req before its ack: still exactly one ack
    acks_before = ack_count;
    cmdq[0].push_back(mk(0, 7, 0, 3, 1));
    wait_done(100);
    repeat (4) @(negedge clk);
    chk("early_drop_single_ack", ack_count - acks_before, 1);

    // Randomised mix of reads, writes, out-of-range addresses and gaps
    for (int k = 0; k < 40; k++) begin
      cmdq[0].push_back(mk($urandom_range(0, 1), $urandom_range(0, 13),
                           $urandom_range(0, 255), $urandom_range(0, 3), 0));
      cmdq[1].push_back(mk($urandom_range(0, 1), $urandom_range(0, 13),
                           $urandom_range(0, 255), $urandom_range(0, 3), 0));
    end
    wait_done(3000);

    chk("mem_en_pulses", en_pulses, inrange_cmds);
    chk("idle_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
